// File: rtl/cpu_pkg.sv
// Shared MCS8 definitions: opcode class patterns, flag indices, condition-select
// encoding and flag write masks.
package cpu_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_P = 3;

    typedef enum logic [1:0] {
        SEL_C = 2'b00,
        SEL_Z = 2'b01,
        SEL_S = 2'b10,
        SEL_P = 2'b11
    } cond_sel_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_JMP,
        CLS_CAL,
        CLS_RET
    } op_class_e;

    localparam logic [1:0] OPC_HI_JC  = 2'b01;
    localparam logic [1:0] OPC_HI_RET = 2'b00;
    localparam logic [1:0] OPC_LO_JMP = 2'b00;
    localparam logic [1:0] OPC_LO_CAL = 2'b10;
    localparam logic [1:0] OPC_LO_RET = 2'b11;

    localparam logic [3:0] MASK_ALU = 4'b1111;
    localparam logic [3:0] MASK_ROT = 4'b0001;

    function automatic op_class_e decode_class(input logic [7:0] op);
        op_class_e cls;
        cls = CLS_NONE;
        if (op[7:6] == OPC_HI_JC && op[1:0] == OPC_LO_JMP) cls = CLS_JMP;
        else if (op[7:6] == OPC_HI_JC && op[1:0] == OPC_LO_CAL) cls = CLS_CAL;
        else if (op[7:6] == OPC_HI_RET && op[1:0] == OPC_LO_RET) cls = CLS_RET;
        return cls;
    endfunction

endpackage

// File: rtl/cpu_cond_resolve_if.sv
// D/E-stage signal bundle of the conditional branch resolver.
interface cpu_cond_resolve_if #(
    parameter int NFLAG = 4,
    parameter int CNTW  = 16
);
    logic             D_VALID_I;
    logic [7:0]       D_OPCODE_I;
    logic             E_VALID_I;
    logic [NFLAG-1:0] E_FWR_I;
    logic [NFLAG-1:0] E_STATUS_I;
    logic             E_STATUS_RDY_I;
    logic             ADV_I;
    logic             FLUSH_I;
    logic             COND_JMP_O;
    logic             COND_CAL_O;
    logic             COND_RET_O;
    logic             STALL_O;
    logic [NFLAG-1:0] FLAGS_O;
    logic [CNTW-1:0]  PERF_STALL_O;

    modport master (
        output D_VALID_I, D_OPCODE_I, E_VALID_I, E_FWR_I, E_STATUS_I,
               E_STATUS_RDY_I, ADV_I, FLUSH_I,
        input  COND_JMP_O, COND_CAL_O, COND_RET_O, STALL_O, FLAGS_O, PERF_STALL_O
    );

    modport slave (
        input  D_VALID_I, D_OPCODE_I, E_VALID_I, E_FWR_I, E_STATUS_I,
               E_STATUS_RDY_I, ADV_I, FLUSH_I,
        output COND_JMP_O, COND_CAL_O, COND_RET_O, STALL_O, FLAGS_O, PERF_STALL_O
    );
endinterface

// File: rtl/cpu_flag_tracker.sv
// In-flight flag writer tracker: DEPTH-1 entry shift register, commit into the
// architectural flags, and per-bit youngest-writer forwarding.
module cpu_flag_tracker #(
    parameter int NFLAG = 4,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             flush,
    input  logic             e_valid,
    input  logic [NFLAG-1:0] e_fwr,
    input  logic [NFLAG-1:0] e_status,
    input  logic             e_rdy,
    output logic [NFLAG-1:0] eff_flags,
    output logic [NFLAG-1:0] arch_flags
);

    logic [DEPTH-1:1] vld_d, vld_q;
    logic [NFLAG-1:0] mask_d [DEPTH-1:1];
    logic [NFLAG-1:0] mask_q [DEPTH-1:1];
    logic [NFLAG-1:0] val_d  [DEPTH-1:1];
    logic [NFLAG-1:0] val_q  [DEPTH-1:1];
    logic [NFLAG-1:0] flags_d, flags_q;

    always_comb begin
        vld_d   = vld_q;
        mask_d  = mask_q;
        val_d   = val_q;
        flags_d = flags_q;
        if (flush) begin
            vld_d = '0;
        end else if (adv) begin
            if (vld_q[DEPTH-1]) begin
                flags_d = (flags_q & ~mask_q[DEPTH-1]) | (val_q[DEPTH-1] & mask_q[DEPTH-1]);
            end
            for (int i = DEPTH-1; i >= 2; i--) begin
                vld_d[i]  = vld_q[i-1];
                mask_d[i] = mask_q[i-1];
                val_d[i]  = val_q[i-1];
            end
            vld_d[1]  = e_valid;
            mask_d[1] = e_fwr;
            val_d[1]  = e_status;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            flags_q <= '0;
        end else begin
            vld_q   <= vld_d;
            flags_q <= flags_d;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        mask_q <= mask_d;
        val_q  <= val_d;
    end

    always_comb begin
        logic [NFLAG-1:0] m;
        eff_flags = flags_q;
        for (int i = DEPTH-1; i >= 1; i--) begin
            m         = {NFLAG{vld_q[i]}} & mask_q[i];
            eff_flags = (eff_flags & ~m) | (val_q[i] & m);
        end
        m         = {NFLAG{e_valid & e_rdy}} & e_fwr;
        eff_flags = (eff_flags & ~m) | (e_status & m);
    end

    assign arch_flags = flags_q;

endmodule

// File: rtl/cpu_cond_resolve.sv
// Conditional JMP/CAL/RET resolver for the MCS8 D stage with flag forwarding,
// stall on unfinished flag producers and a saturating stall counter.
module cpu_cond_resolve
    import cpu_pkg::*;
#(
    parameter int NFLAG = 4,
    parameter int DEPTH = 3,
    parameter int CNTW  = 16
) (
    input logic               CLK_I,
    input logic               RST_I,
    cpu_cond_resolve_if.slave bus
);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + 1'b1;
    endfunction

    op_class_e        cls;
    cond_sel_e        sel;
    logic             uncond, pol, sel_eff, sel_fwr, pending, stall, taken;
    logic [NFLAG-1:0] eff_flags, arch_flags;
    logic [CNTW-1:0]  perf_d, perf_q;

    cpu_flag_tracker #(.NFLAG(NFLAG), .DEPTH(DEPTH)) u_tracker (
        .clk       (CLK_I),
        .rst       (RST_I),
        .adv       (bus.ADV_I),
        .flush     (bus.FLUSH_I),
        .e_valid   (bus.E_VALID_I),
        .e_fwr     (bus.E_FWR_I),
        .e_status  (bus.E_STATUS_I),
        .e_rdy     (bus.E_STATUS_RDY_I),
        .eff_flags (eff_flags),
        .arch_flags(arch_flags)
    );

    always_comb begin
        cls    = decode_class(bus.D_OPCODE_I);
        uncond = bus.D_OPCODE_I[2];
        pol    = bus.D_OPCODE_I[5];
        sel    = cond_sel_e'(bus.D_OPCODE_I[4:3]);
        case (sel)
            SEL_C:   begin sel_eff = eff_flags[FLAG_C]; sel_fwr = bus.E_FWR_I[FLAG_C]; end
            SEL_Z:   begin sel_eff = eff_flags[FLAG_Z]; sel_fwr = bus.E_FWR_I[FLAG_Z]; end
            SEL_S:   begin sel_eff = eff_flags[FLAG_S]; sel_fwr = bus.E_FWR_I[FLAG_S]; end
            default: begin sel_eff = eff_flags[FLAG_P]; sel_fwr = bus.E_FWR_I[FLAG_P]; end
        endcase
        pending = bus.E_VALID_I & sel_fwr & ~bus.E_STATUS_RDY_I;
        stall   = bus.D_VALID_I & (cls != CLS_NONE) & ~uncond & pending;
        taken   = bus.D_VALID_I & ~stall & (uncond | (pol ~^ sel_eff));
        perf_d  = stall ? sat_inc(perf_q) : perf_q;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign bus.COND_JMP_O   = taken & (cls == CLS_JMP);
    assign bus.COND_CAL_O   = taken & (cls == CLS_CAL);
    assign bus.COND_RET_O   = taken & (cls == CLS_RET);
    assign bus.STALL_O      = stall;
    assign bus.FLAGS_O      = arch_flags;
    assign bus.PERF_STALL_O = perf_q;

    // Advancing an unfinished flag producer would capture a non-final value.
    adv_ready_a: assert property (@(posedge CLK_I) disable iff (RST_I)
        !(bus.ADV_I && bus.E_VALID_I && !bus.E_STATUS_RDY_I));

    fwr_legal_a: assert property (@(posedge CLK_I) disable iff (RST_I)
        bus.E_VALID_I |-> (bus.E_FWR_I == '0 || bus.E_FWR_I == NFLAG'(MASK_ALU) ||
                           bus.E_FWR_I == NFLAG'(MASK_ROT)));

endmodule
